// File: rtl/spi_slave_if.sv
// Bus bundle between an SPI master plus its local host and the spi_slave responder.
// The slave modport is the responder's view; the master modport drives the wire and host side.
interface spi_slave_if #(
  parameter int sizeOfData = 8
);
  logic                  SCLK;
  logic                  CS;
  logic                  MOSI;
  logic                  MISO;
  logic                  cpol;
  logic                  cpha;
  logic                  load;
  logic [sizeOfData-1:0] data_write;
  logic [sizeOfData-1:0] data_read;
  logic                  data_valid;
  logic                  frame_error;
  logic                  busy;

  modport slave (
    input  SCLK, CS, MOSI, cpol, cpha, load, data_write,
    output MISO, data_read, data_valid, frame_error, busy
  );

  modport master (
    output SCLK, CS, MOSI, cpol, cpha, load, data_write,
    input  MISO, data_read, data_valid, frame_error, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS/MOSI on clk, shifts one LSB-first word per CS frame
// in all four CPOL/CPHA modes, and replies with a preloaded word on MISO.
module spi_slave #(
  parameter int sizeOfData = 8,
  parameter int syncStages = 2
) (
  input  logic     clk,
  input  logic     rst,
  spi_slave_if.slave bus
);
  localparam int CNT_W = $clog2(sizeOfData + 1);
  localparam logic [sizeOfData-1:0] ONE = {{(sizeOfData-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                state, state_next;
  logic [syncStages-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                  sclk_s, cs_s, mosi_s;
  logic                  sclk_prev, cs_prev;
  logic [sizeOfData-1:0] tx_shift, rx_shift, rx_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  edge_seen, lead, trail, tx_bit;
  logic                  start, sample, drive, done, abort;

  // Stage: input synchronizers plus previous-SCLK register for edge detection
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[syncStages-2:0], bus.SCLK};
    cs_sync   <= {cs_sync[syncStages-2:0], bus.CS};
    mosi_sync <= {mosi_sync[syncStages-2:0], bus.MOSI};
    sclk_prev <= sclk_s;
  end

  assign sclk_s    = sclk_sync[syncStages-1];
  assign cs_s      = cs_sync[syncStages-1];
  assign mosi_s    = mosi_sync[syncStages-1];
  assign edge_seen = sclk_s != sclk_prev;
  assign lead      = edge_seen && (sclk_s != bus.cpol);
  assign trail     = edge_seen && (sclk_s == bus.cpol);
  assign tx_bit    = |(tx_shift & (ONE << bit_cnt));
  assign rx_next   = rx_shift | ({{(sizeOfData-1){1'b0}}, mosi_s} << bit_cnt);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    sample     = 1'b0;
    drive      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_prev && !cs_s) begin
          state_next = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        // CS rising wins over a coincident SCLK edge
        if (cs_s) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (bus.cpha ? trail : lead) begin
          sample = 1'b1;
          if (bit_cnt == CNT_W'(sizeOfData - 1)) begin
            done       = 1'b1;
            state_next = HOLD;
          end
        end else if ((bus.cpha ? lead : trail) && (bit_cnt < CNT_W'(sizeOfData))) begin
          drive = 1'b1;
        end
      end
      HOLD: begin
        if (cs_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage: FSM state, shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cs_prev         <= 1'b0;
      bit_cnt         <= '0;
      tx_shift        <= '0;
      rx_shift        <= '0;
      bus.MISO        <= 1'b0;
      bus.data_read   <= '0;
      bus.data_valid  <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      state           <= state_next;
      cs_prev         <= cs_s;
      bus.data_valid  <= done;
      bus.frame_error <= abort;
      if (state == IDLE && bus.load) tx_shift <= bus.data_write;
      if (start) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        // A load on the same clk as the CS fall supplies the first reply bit
        bus.MISO <= bus.cpha ? 1'b0 : (bus.load ? bus.data_write[0] : tx_shift[0]);
      end
      if (sample) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 1'b1;
        if (done) bus.data_read <= rx_next;
      end
      if (drive) bus.MISO <= tx_bit;
      if (state_next == IDLE) bus.MISO <= 1'b0;
    end
  end

  assign bus.busy = (state != IDLE);
endmodule
